// File: rtl/a2d_arbiter_if.sv
// ----------------------------------------------------------------------------
// a2d_arbiter_if
// Bundles every signal between the two A2D requesters, the shared A2D SPI
// interface block and the arbiter.
//   slave  : arbiter side (receives requests and completions, drives grants,
//            done pulses, the start pulse, the channel and the result)
//   master : environment side (requesters plus A2D interface, or a bench)
// Signals:
//   req0/chnnl0/gnt0/done0 : port 0 (IR sensor sweep)
//   req1/chnnl1/gnt1/done1 : port 1 (auxiliary monitor)
//   strt_cnv/chnnl         : start pulse and channel to the A2D interface
//   cnv_cmplt/A2D_res      : completion pulse and raw result from the A2D
//   res/busy/timeout       : latched result, activity flag, abort pulse
// ----------------------------------------------------------------------------
interface a2d_arbiter_if;
  logic        req0;
  logic [2:0]  chnnl0;
  logic        gnt0;
  logic        done0;
  logic        req1;
  logic [2:0]  chnnl1;
  logic        gnt1;
  logic        done1;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic [11:0] res;
  logic        busy;
  logic        timeout;

  modport slave (
    input  req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
    output gnt0, done0, gnt1, done1, strt_cnv, chnnl, res, busy, timeout
  );

  modport master (
    output req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
    input  gnt0, done0, gnt1, done1, strt_cnv, chnnl, res, busy, timeout
  );
endinterface

// File: rtl/a2d_arbiter.sv
// ----------------------------------------------------------------------------
// a2d_arbiter
// Shares one A2D converter between two requesters with round-robin
// arbitration. A granted port's channel is latched and held for
// SETTLE_CYCLES cycles before a single-cycle start pulse; the arbiter then
// waits up to TIMEOUT_CYCLES cycles for the completion pulse, latches the
// result (or zero on abort) and pulses the owner's done line.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high, highest priority
//   bus  : a2d_arbiter_if.slave (requests, grants, done pulses, A2D side,
//          latched result, busy and timeout)
// All outputs are driven directly from registers.
// ----------------------------------------------------------------------------
module a2d_arbiter #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  a2d_arbiter_if.slave  bus
);

  localparam int MAX_CNT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt,   w_nxt_cnt;
  logic             r_last,  w_nxt_last;   // last-served port
  logic             r_owner, w_nxt_owner;  // port owning the current conversion
  logic             r_gnt0,  w_nxt_gnt0;
  logic             r_gnt1,  w_nxt_gnt1;
  logic             r_done0, w_nxt_done0;
  logic             r_done1, w_nxt_done1;
  logic             r_strt,  w_nxt_strt;
  logic [2:0]       r_chnnl, w_nxt_chnnl;
  logic [11:0]      r_res,   w_nxt_res;
  logic             r_busy,  w_nxt_busy;
  logic             r_tmo,   w_nxt_tmo;
  logic             w_pick;

  // On a tie the port that was not served last wins; otherwise the lone
  // requester wins (req1 alone -> 1, req0 alone -> 0).
  assign w_pick = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_strt  <= 1'b0;
      r_chnnl <= 3'd0;
      r_res   <= 12'h000;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_last  <= w_nxt_last;
      r_owner <= w_nxt_owner;
      r_gnt0  <= w_nxt_gnt0;
      r_gnt1  <= w_nxt_gnt1;
      r_done0 <= w_nxt_done0;
      r_done1 <= w_nxt_done1;
      r_strt  <= w_nxt_strt;
      r_chnnl <= w_nxt_chnnl;
      r_res   <= w_nxt_res;
      r_busy  <= w_nxt_busy;
      r_tmo   <= w_nxt_tmo;
    end
  end

  // Next-state and next-output logic. Pulsed outputs default low so they
  // only live for the single cycle after the edge that sets them.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_last  = r_last;
    w_nxt_owner = r_owner;
    w_nxt_gnt0  = r_gnt0;
    w_nxt_gnt1  = r_gnt1;
    w_nxt_done0 = 1'b0;
    w_nxt_done1 = 1'b0;
    w_nxt_strt  = 1'b0;
    w_nxt_chnnl = r_chnnl;
    w_nxt_res   = r_res;
    w_nxt_busy  = r_busy;
    w_nxt_tmo   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          w_nxt_owner = w_pick;
          w_nxt_last  = w_pick;
          w_nxt_gnt0  = ~w_pick;
          w_nxt_gnt1  = w_pick;
          w_nxt_chnnl = w_pick ? bus.chnnl1 : bus.chnnl0;
          w_nxt_busy  = 1'b1;
          w_nxt_cnt   = '0;
          w_nxt_state = S_SETTLE;
        end
      end

      S_SETTLE: begin
        // Start pulse is registered, so it is raised on the edge that ends
        // the last settle cycle and is visible during START.
        if (r_cnt == SETTLE_LAST) begin
          w_nxt_strt  = 1'b1;
          w_nxt_cnt   = '0;
          w_nxt_state = S_START;
        end else begin
          w_nxt_cnt = r_cnt + CNT_ONE;
        end
      end

      S_START: begin
        w_nxt_cnt   = '0;
        w_nxt_state = S_WAIT;
      end

      S_WAIT: begin
        // Completion is checked first so a pulse on the final allowed cycle
        // still delivers a real result.
        if (bus.cnv_cmplt) begin
          w_nxt_res   = bus.A2D_res;
          w_nxt_done0 = ~r_owner;
          w_nxt_done1 = r_owner;
          w_nxt_state = S_DONE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_nxt_res   = 12'h000;
          w_nxt_tmo   = 1'b1;
          w_nxt_done0 = ~r_owner;
          w_nxt_done1 = r_owner;
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_cnt = r_cnt + CNT_ONE;
        end
      end

      S_DONE: begin
        w_nxt_gnt0  = 1'b0;
        w_nxt_gnt1  = 1'b0;
        w_nxt_busy  = 1'b0;
        w_nxt_state = S_IDLE;
      end

      default: begin
        w_nxt_gnt0  = 1'b0;
        w_nxt_gnt1  = 1'b0;
        w_nxt_busy  = 1'b0;
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.done0    = r_done0;
  assign bus.done1    = r_done1;
  assign bus.strt_cnv = r_strt;
  assign bus.chnnl    = r_chnnl;
  assign bus.res      = r_res;
  assign bus.busy     = r_busy;
  assign bus.timeout  = r_tmo;

endmodule

// File: tb/tb_a2d_arbiter.sv
// ----------------------------------------------------------------------------
// tb_a2d_arbiter
// Directed bench for a2d_arbiter with SETTLE_CYCLES=4, TIMEOUT_CYCLES=16.
// A cycle table covers reset and one full conversion on port 0; hand-written
// sequences cover round-robin alternation, timeout, completion on the final
// wait cycle, request drop after grant and reset during WAIT.
// ----------------------------------------------------------------------------
module tb_a2d_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  a2d_arbiter_if bus ();

  a2d_arbiter #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output vector order: gnt0 gnt1 done0 done1 strt ch[2:0] res[11:0] busy timeout
  function automatic logic [22:0] mk(input logic g0, input logic g1, input logic d0,
                                     input logic d1, input logic st, input logic [2:0] ch,
                                     input logic [11:0] r, input logic b, input logic to);
    return {g0, g1, d0, d1, st, ch, r, b, to};
  endfunction

  function automatic logic [22:0] outs();
    return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.strt_cnv,
            bus.chnnl, bus.res, bus.busy, bus.timeout};
  endfunction

  typedef struct {
    logic        rst;
    logic        req0;
    logic [2:0]  ch0;
    logic        req1;
    logic [2:0]  ch1;
    logic        cmplt;
    logic [11:0] a2d;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (!(bus.gnt0 || bus.gnt1) && n < 10) begin
      step();
      n++;
    end
    chk("wait_gnt", 32'(bus.gnt0 | bus.gnt1), 32'd1);
  endtask

  task automatic wait_strt();
    int n;
    n = 0;
    while (!bus.strt_cnv && n < 20) begin
      chk("one_gnt", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      step();
      n++;
    end
    chk("wait_strt", 32'(bus.strt_cnv), 32'd1);
  endtask

  task automatic run_conv(input logic port, input logic [2:0] ch, input logic [11:0] val);
    wait_gnt();
    chk("gnt_port", 32'({bus.gnt1, bus.gnt0}), port ? 32'd2 : 32'd1);
    chk("gnt_chnnl", 32'(bus.chnnl), 32'(ch));
    wait_strt();
    step();
    bus.cnv_cmplt = 1'b1;
    bus.A2D_res   = val;
    step();
    bus.cnv_cmplt = 1'b0;
    chk("done_port", 32'({bus.done1, bus.done0}), port ? 32'd2 : 32'd1);
    chk("done_res", 32'(bus.res), 32'(val));
    step();
    chk("gnt_release", 32'({bus.gnt1, bus.gnt0, bus.busy}), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.req0      = 1'b0;
    bus.chnnl0    = 3'd0;
    bus.req1      = 1'b0;
    bus.chnnl1    = 3'd0;
    bus.cnv_cmplt = 1'b0;
    bus.A2D_res   = 12'h000;

    // Reset then one port-0 conversion on channel 4; channel change after
    // grant and a spurious completion in SETTLE must have no effect.
    tbl[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 12'h000, mk(0,0,0,0,0,3'd0,12'h000,0,0)};
    tbl[1] = '{1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 12'h000, mk(1,0,0,0,0,3'd4,12'h000,1,0)};
    tbl[2] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 12'h000, mk(1,0,0,0,0,3'd4,12'h000,1,0)};
    tbl[3] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1, 12'hFFF, mk(1,0,0,0,0,3'd4,12'h000,1,0)};
    tbl[4] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 12'h000, mk(1,0,0,0,0,3'd4,12'h000,1,0)};
    tbl[5] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 12'h000, mk(1,0,0,0,1,3'd4,12'h000,1,0)};
    tbl[6] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 12'h000, mk(1,0,0,0,0,3'd4,12'h000,1,0)};
    tbl[7] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1, 12'hA5C, mk(1,0,1,0,0,3'd4,12'hA5C,1,0)};
    tbl[8] = '{1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 1'b0, 12'h000, mk(0,0,0,0,0,3'd4,12'hA5C,0,0)};
    tbl[9] = '{1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 1'b1, 12'h123, mk(0,0,0,0,0,3'd4,12'hA5C,0,0)};

    for (int i = 0; i < 10; i++) begin
      rst           = tbl[i].rst;
      bus.req0      = tbl[i].req0;
      bus.chnnl0    = tbl[i].ch0;
      bus.req1      = tbl[i].req1;
      bus.chnnl1    = tbl[i].ch1;
      bus.cnv_cmplt = tbl[i].cmplt;
      bus.A2D_res   = tbl[i].a2d;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    bus.cnv_cmplt = 1'b0;

    // Both ports requesting from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req0   = 1'b1;
    bus.chnnl0 = 3'd2;
    bus.req1   = 1'b1;
    bus.chnnl1 = 3'd6;
    run_conv(1'b0, 3'd2, 12'h111);
    run_conv(1'b1, 3'd6, 12'h222);
    run_conv(1'b0, 3'd2, 12'h333);
    run_conv(1'b1, 3'd6, 12'h444);

    // Port 1 alone, no completion: abort after 16 WAIT cycles.
    bus.req0   = 1'b0;
    bus.chnnl1 = 3'd5;
    wait_gnt();
    chk("to_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd2);
    chk("to_chnnl", 32'(bus.chnnl), 32'd5);
    wait_strt();
    for (int k = 0; k < 16; k++) begin
      step();
      chk("to_early", 32'({bus.done1, bus.timeout}), 32'd0);
    end
    step();
    chk("to_done", 32'({bus.done1, bus.done0, bus.timeout}), 32'b101);
    chk("to_res", 32'(bus.res), 32'h000);
    bus.req1 = 1'b0;
    step();
    chk("to_clear", 32'({bus.done1, bus.timeout, bus.busy, bus.gnt1}), 32'd0);

    // Port 0, request dropped after grant, completion on the last WAIT cycle.
    bus.req0   = 1'b1;
    bus.chnnl0 = 3'd1;
    wait_gnt();
    chk("edge_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd1);
    bus.req0 = 1'b0;
    wait_strt();
    for (int k = 0; k < 16; k++) begin
      step();
    end
    chk("edge_nodone", 32'({bus.done0, bus.timeout}), 32'd0);
    bus.cnv_cmplt = 1'b1;
    bus.A2D_res   = 12'h7E1;
    step();
    bus.cnv_cmplt = 1'b0;
    chk("edge_done", 32'({bus.done0, bus.timeout}), 32'b10);
    chk("edge_res", 32'(bus.res), 32'h7E1);
    step();
    chk("edge_idle", 32'({bus.busy, bus.gnt0}), 32'd0);

    // Reset during WAIT with port 0 granted.
    bus.req0   = 1'b1;
    bus.chnnl0 = 3'd3;
    wait_gnt();
    wait_strt();
    step();
    step();
    chk("rw_busy", 32'({bus.gnt0, bus.busy}), 32'b11);
    rst = 1'b1;
    step();
    chk("rw_reset", 32'(outs()), 32'd0);
    rst           = 1'b0;
    bus.req0      = 1'b0;
    bus.cnv_cmplt = 1'b1;
    bus.A2D_res   = 12'hABC;
    step();
    chk("rw_ignore", 32'(outs()), 32'd0);
    bus.cnv_cmplt = 1'b0;
    bus.req0      = 1'b1;
    bus.chnnl0    = 3'd2;
    bus.req1      = 1'b1;
    bus.chnnl1    = 3'd7;
    step();
    chk("rw_tie", 32'({bus.gnt1, bus.gnt0}), 32'd1);
    chk("rw_chnnl", 32'(bus.chnnl), 32'd2);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
